// File: rtl/max_abs_identifier_pkg.sv
// Shared types for the matching-pursuit max-ident path: fixed-point word,
// result bundle, scan FSM encoding and the saturation ceiling.
package max_abs_identifier_pkg;

  localparam int FP_W      = 32;
  localparam int MI_ADDR_W = 8;

  typedef logic signed [FP_W-1:0] fp_32_t;

  typedef struct packed {
    fp_32_t                 value;
    logic [MI_ADDR_W-1:0]   location;
  } max_ident_result_t;

  typedef enum logic [1:0] {
    MI_IDLE  = 2'd0,
    MI_FETCH = 2'd1,
    MI_DRAIN = 2'd2
  } mi_state_t;

  localparam fp_32_t FP_32_MAX_POS = 32'h7FFF_FFFF;

endpackage

// File: rtl/max_abs_identifier_abs_sat.sv
// Combinational saturated absolute value: the most negative code maps to the
// largest positive code instead of wrapping back to itself.
module max_abs_identifier_abs_sat #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic signed [DATA_WIDTH-1:0] v);
    if (!v[DATA_WIDTH-1])
      sat_abs = v;
    else if (v[DATA_WIDTH-2:0] == '0)
      sat_abs = MAX_POS;
    else
      sat_abs = -v;
  endfunction

  assign y = sat_abs(x);

endmodule

// File: rtl/max_abs_identifier.sv
// Streams products[0..count-1] from the inner-product RAM and reports the
// entry with the largest saturated magnitude (lowest index wins on ties).
module max_abs_identifier
  import max_abs_identifier_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic [DATA_WIDTH-1:0] max_abs,
  output logic [ADDR_WIDTH-1:0] max_location
);

  localparam logic [1:0] ST_IDLE  = MI_IDLE;
  localparam logic [1:0] ST_FETCH = MI_FETCH;
  localparam logic [1:0] ST_DRAIN = MI_DRAIN;

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   cnt_p0;
  logic [ADDR_WIDTH:0]   req_count;
  logic [ADDR_WIDTH:0]   next_addr;
  logic [ADDR_WIDTH:0]   last_addr;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] abs_p1;
  logic                  update;

  always_comb begin
    req_count = (count > MAX_COUNT) ? MAX_COUNT : count;
    next_addr = {1'b0, read_addr} + ONE;
    last_addr = cnt_p0 - ONE;
    update    = vld_p1 && (abs_p1 > max_abs);
  end

  max_abs_identifier_abs_sat #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_abs_sat (
    .x (read_data),
    .y (abs_p1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt_p0       <= '0;
      read_en      <= 1'b0;
      read_addr    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      max_value    <= '0;
      max_abs      <= '0;
      max_location <= '0;
    end else begin
      done <= 1'b0;

      // p1: RAM word for the address issued last cycle is on read_data
      vld_p1  <= read_en;
      addr_p1 <= read_addr;
      if (update) begin
        max_abs      <= abs_p1;
        max_value    <= read_data;
        max_location <= addr_p1;
      end

      // p0: address issue / scan control
      case (state)
        ST_IDLE: begin
          if (start) begin
            max_abs      <= '0;
            max_value    <= '0;
            max_location <= '0;
            if (req_count == '0) begin
              done <= 1'b1;
            end else begin
              cnt_p0    <= req_count;
              read_en   <= 1'b1;
              read_addr <= '0;
              busy      <= 1'b1;
              state     <= (req_count == ONE) ? ST_DRAIN : ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          read_addr <= next_addr[ADDR_WIDTH-1:0];
          if (next_addr == last_addr) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          read_en <= 1'b0;
          // last word is being compared when the valid flag outlives read_en
          if (vld_p1 && !read_en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
